// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Control-side companion to the i2d/d2a/a2w pipeline registers. It decides
// when decode holds, when d2a receives a bubble, when stages flush, and when
// fetch stalls or redirects.
//   * A per-register pending-write counter tracks every issued writer until
//     its writeback retires. A source register with a nonzero count is a RAW
//     hazard. A destination whose count is saturated is an overflow hold.
//   * A two-state RUN/FLUSH machine sequences a taken-branch redirect.
//     FLUSH squashes the wrong-path instruction fetched in the redirect cycle.
//
// Optional feature macro: HAZARD_FWD_EN
//   When it is defined, a source with exactly one pending write whose
//   writeback is retiring this cycle counts as ready. The datapath bypasses
//   the write data, so the consumer issues in the writeback cycle.
//
// Ports
//   clk, n_rst            clock; synchronous active-low reset
//   d_valid               decode instruction valid
//   d_src0/1(_en)         decode source registers and their use enables
//   d_dst(_en)            decode destination register and write enable
//   w_valid, w_en, w_addr writeback retire of a register write
//   redirect, redirect_pc ALU-stage taken branch and its target
//   fetch_stall           hold the fetch PC
//   i2d_hold              i2d register keeps its contents
//   d2a_bubble            d2a loads valid=0
//   i2d_flush, d2a_flush  clear stage valid
//   pc_load, pc_target    fetch loads pc_target
//   issue                 decode instruction advances this cycle
//   stall_cycles          saturating count of RAW-hazard stall cycles
//   sb_err                sticky error: scoreboard underflow or redirect in FLUSH
//   dbg_state             current FSM state (1 = FLUSH)
//
// Handshake: d_valid acts as "valid" and issue as "valid & ready". An
// instruction advances out of decode only in a cycle where issue=1. While
// d_valid=1 and issue=0, decode must keep presenting the same instruction.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int NUM_REGS = 16,
   parameter int REG_AW   = 4,
   parameter int PC_W     = 16,
   parameter int CNT_W    = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              d_valid,
   input  logic              d_src0_en,
   input  logic              d_src1_en,
   input  logic [REG_AW-1:0] d_src0,
   input  logic [REG_AW-1:0] d_src1,
   input  logic              d_dst_en,
   input  logic [REG_AW-1:0] d_dst,
   input  logic              w_valid,
   input  logic              w_en,
   input  logic [REG_AW-1:0] w_addr,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              fetch_stall,
   output logic              i2d_hold,
   output logic              d2a_bubble,
   output logic              i2d_flush,
   output logic              d2a_flush,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_target,
   output logic              issue,
   output logic [15:0]       stall_cycles,
   output logic              sb_err,
   output logic              dbg_state
);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q [NUM_REGS];
   logic [PC_W-1:0]    target_q;
   logic [15:0]        stall_q;
   logic               err_q;

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   logic             w_hit;
   logic [CNT_W-1:0] cnt_src0, cnt_src1, cnt_dst, cnt_wb;
   logic             fwd0, fwd1;
   logic             busy0, busy1;
   logic             raw, ovf, hold;

   assign w_hit    = w_valid & w_en;
   assign cnt_src0 = cnt_q[d_src0];
   assign cnt_src1 = cnt_q[d_src1];
   assign cnt_dst  = cnt_q[d_dst];
   assign cnt_wb   = cnt_q[w_addr];

`ifdef HAZARD_FWD_EN
   // The last outstanding write to the source is retiring now, and its data
   // is bypassed, so the source is already usable.
   assign fwd0 = w_hit && (w_addr == d_src0) && (cnt_src0 == CNT_W'(1));
   assign fwd1 = w_hit && (w_addr == d_src1) && (cnt_src1 == CNT_W'(1));
`else
   assign fwd0 = 1'b0;
   assign fwd1 = 1'b0;
`endif

   assign busy0 = d_src0_en & (cnt_src0 != '0) & ~fwd0;
   assign busy1 = d_src1_en & (cnt_src1 != '0) & ~fwd1;
   assign raw   = d_valid & (busy0 | busy1);
   // A saturated counter cannot record another writer, so the writer waits.
   assign ovf   = d_valid & d_dst_en & (cnt_dst == {CNT_W{1'b1}});
   assign hold  = raw | ovf;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------
   // FSM: next state and pipeline controls.
   // While reset is asserted, every control stays low. This drops any
   // redirect or flush in progress.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      fetch_stall = 1'b0;
      i2d_hold    = 1'b0;
      d2a_bubble  = 1'b0;
      i2d_flush   = 1'b0;
      d2a_flush   = 1'b0;
      pc_load     = 1'b0;
      pc_target   = target_q;
      issue       = 1'b0;
      if (!n_rst) begin
         pc_target = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (redirect) begin
                  // Redirect wins over any hold, and fetch must move to the target.
                  i2d_flush = 1'b1;
                  d2a_flush = 1'b1;
                  pc_load   = 1'b1;
                  pc_target = redirect_pc;
                  state_d   = S_FLUSH;
               end else if (hold) begin
                  fetch_stall = 1'b1;
                  i2d_hold    = 1'b1;
                  d2a_bubble  = 1'b1;
               end else begin
                  issue = d_valid;
               end
            end
            S_FLUSH: begin
               i2d_flush  = 1'b1;
               d2a_bubble = 1'b1;
               state_d    = S_RUN;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Pending-write scoreboard. If the same register is incremented and
   // decremented in one cycle, its count is unchanged. A decrement at zero
   // leaves the count at zero and is reported through sb_err.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if ((issue & d_dst_en & (d_dst == REG_AW'(i))) &&
                !(w_hit && (w_addr == REG_AW'(i)))) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if ((w_hit && (w_addr == REG_AW'(i))) &&
                         !(issue & d_dst_en & (d_dst == REG_AW'(i))) &&
                         (cnt_q[i] != '0)) begin
               cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Redirect target, stall statistics and sticky error
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         target_q <= '0;
         stall_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == S_RUN && redirect) target_q <= redirect_pc;
         // Only RAW stalls are counted. Overflow holds and redirect cycles are not.
         if (state_q == S_RUN && !redirect && raw && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         // A redirect arriving in FLUSH is ignored and flagged.
         if ((w_hit && cnt_wb == '0) || (state_q == S_FLUSH && redirect))
            err_q <= 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign sb_err       = err_q;
   assign dbg_state    = (state_q == S_FLUSH);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Bench for pipe_hazard_ctrl. The reference model keeps one integer per
// register: the number of issued writers that have not yet retired. It also
// holds a FLUSH flag, the last redirect target, a stall counter and a sticky
// error bit. Expected values come from that model. Directed sequences exercise
// the listed scenarios, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int NR     = 16;
   localparam int REG_AW = 4;
   localparam int PC_W   = 16;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic n_rst;

   // ---------------- DUT signals ----------------
   logic              d_valid, d_src0_en, d_src1_en, d_dst_en;
   logic [REG_AW-1:0] d_src0, d_src1, d_dst, w_addr;
   logic              w_valid, w_en, redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic              fetch_stall, i2d_hold, d2a_bubble, i2d_flush, d2a_flush;
   logic              pc_load, issue, sb_err, dbg_state;
   logic [PC_W-1:0]   pc_target;
   logic [15:0]       stall_cycles;

   pipe_hazard_ctrl #(.NUM_REGS(NR), .REG_AW(REG_AW), .PC_W(PC_W), .CNT_W(2)) dut (
      .clk(clk), .n_rst(n_rst),
      .d_valid(d_valid), .d_src0_en(d_src0_en), .d_src1_en(d_src1_en),
      .d_src0(d_src0), .d_src1(d_src1), .d_dst_en(d_dst_en), .d_dst(d_dst),
      .w_valid(w_valid), .w_en(w_en), .w_addr(w_addr),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fetch_stall(fetch_stall), .i2d_hold(i2d_hold), .d2a_bubble(d2a_bubble),
      .i2d_flush(i2d_flush), .d2a_flush(d2a_flush), .pc_load(pc_load),
      .pc_target(pc_target), .issue(issue), .stall_cycles(stall_cycles),
      .sb_err(sb_err), .dbg_state(dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_cnt [NR];
   bit          m_flush;
   int          m_stall;
   bit          m_err;
   logic [15:0] m_target;
   // expected combinational outputs for the current cycle
   logic        e_fetch_stall, e_i2d_hold, e_d2a_bubble, e_i2d_flush, e_d2a_flush;
   logic        e_pc_load, e_issue, e_raw;
   logic [15:0] e_target;
   // scoreboard of expected control flags
   logic [6:0]  exp_q[$];

   function automatic bit src_ready(input logic [REG_AW-1:0] a);
      if (m_cnt[a] == 0) return 1'b1;
      return FWD && m_cnt[a] == 1 && w_valid && w_en && w_addr == a;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_flush  = 1'b0;
      m_stall  = 0;
      m_err    = 1'b0;
      m_target = '0;
   endtask

   task automatic model_eval();
      bit ovf;
      e_fetch_stall = 0; e_i2d_hold = 0; e_d2a_bubble = 0;
      e_i2d_flush = 0; e_d2a_flush = 0; e_pc_load = 0; e_issue = 0; e_raw = 0;
      e_target = m_target;
      if (!n_rst) begin
         e_target = '0;
      end else if (m_flush) begin
         e_i2d_flush = 1; e_d2a_bubble = 1;
      end else if (redirect) begin
         e_i2d_flush = 1; e_d2a_flush = 1; e_pc_load = 1; e_target = redirect_pc;
      end else begin
         e_raw = d_valid && ((d_src0_en && !src_ready(d_src0)) ||
                             (d_src1_en && !src_ready(d_src1)));
         ovf   = d_valid && d_dst_en && m_cnt[d_dst] == 3;
         if (e_raw || ovf) begin
            e_fetch_stall = 1; e_i2d_hold = 1; e_d2a_bubble = 1;
         end else begin
            e_issue = d_valid;
         end
      end
   endtask

   task automatic model_update();
      if (!n_rst) begin
         model_reset();
         return;
      end
      if (m_flush) begin
         if (redirect) m_err = 1'b1;
         m_flush = 1'b0;
      end else if (redirect) begin
         m_flush  = 1'b1;
         m_target = redirect_pc;
      end else if (e_raw && m_stall < 65535) begin
         m_stall++;
      end
      if (w_valid && w_en && m_cnt[w_addr] == 0) m_err = 1'b1;
      if (e_issue && d_dst_en) m_cnt[d_dst]++;
      if (w_valid && w_en && m_cnt[w_addr] > 0) m_cnt[w_addr]--;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      d_valid = 0; d_src0_en = 0; d_src1_en = 0; d_dst_en = 0;
      d_src0 = '0; d_src1 = '0; d_dst = '0;
      w_valid = 0; w_en = 0; w_addr = '0;
      redirect = 0; redirect_pc = '0;
   endtask

   // Checks one cycle at the negative edge, then advances past the next
   // rising edge. Inputs must already be set.
   task automatic cycle();
      logic [6:0] v;
      @(negedge clk);
      model_eval();
      exp_q.push_back({e_fetch_stall, e_i2d_hold, e_d2a_bubble, e_i2d_flush,
                       e_d2a_flush, e_pc_load, e_issue});
      v = exp_q.pop_front();
      check("fetch_stall", fetch_stall, v[6]);
      check("i2d_hold",    i2d_hold,    v[5]);
      check("d2a_bubble",  d2a_bubble,  v[4]);
      check("i2d_flush",   i2d_flush,   v[3]);
      check("d2a_flush",   d2a_flush,   v[2]);
      check("pc_load",     pc_load,     v[1]);
      check("issue",       issue,       v[0]);
      check("pc_target",   pc_target,   e_target);
      check("stall_cycles", stall_cycles, m_stall);
      check("sb_err",      sb_err,      m_err);
      check("dbg_state",   dbg_state,   m_flush);
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      n_rst = 0;
      cycle();
      n_rst = 1;
   endtask

   task automatic dec(input bit dst_en, input int dst, input bit s0_en, input int s0);
      d_valid = 1; d_dst_en = dst_en; d_dst = REG_AW'(dst);
      d_src0_en = s0_en; d_src0 = REG_AW'(s0); d_src1_en = 0;
   endtask

   task automatic wb(input int a);
      w_valid = 1; w_en = 1; w_addr = REG_AW'(a);
   endtask

   task automatic rand_inputs(input bit safe_wb);
      int pend[$];
      d_valid = 1'($urandom_range(0, 1));
      d_src0_en = 1'($urandom_range(0, 1)); d_src1_en = 1'($urandom_range(0, 1));
      d_dst_en  = 1'($urandom_range(0, 1));
      d_src0 = REG_AW'($urandom_range(0, NR-1));
      d_src1 = REG_AW'($urandom_range(0, NR-1));
      d_dst  = REG_AW'($urandom_range(0, NR-1));
      redirect_pc = PC_W'($urandom);
      if (safe_wb) begin
         for (int i = 0; i < NR; i++) if (m_cnt[i] > 0) pend.push_back(i);
         w_valid = 0; w_en = 0; w_addr = REG_AW'($urandom_range(0, NR-1));
         if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
            w_valid = 1; w_en = 1'($urandom_range(0, 7) != 0);
            w_addr  = REG_AW'(pend[$urandom_range(0, pend.size()-1)]);
         end
         redirect = !m_flush && $urandom_range(0, 24) == 0;
      end else begin
         w_valid = 1'($urandom_range(0, 1)); w_en = 1'($urandom_range(0, 1));
         w_addr  = REG_AW'($urandom_range(0, NR-1));
         redirect = 1'($urandom_range(0, 1));
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      idle();
      n_rst = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_reset();

      // 1: reset while every input toggles; then release with live decode
      for (int i = 0; i < 6; i++) begin rand_inputs(1'b0); n_rst = 0; cycle(); end
      for (int i = 0; i < 6; i++) begin rand_inputs(1'b1); redirect = 0; cycle(); end

      // 2: r3 producer, then consumer stalls until r3 writeback
      do_reset();
      idle(); dec(1, 3, 0, 0); cycle();
      idle(); dec(0, 0, 1, 3); cycle();
      idle(); dec(0, 0, 1, 3); wb(3); cycle();
      idle(); dec(0, 0, 1, 3); cycle();
      idle(); cycle();
      check("t2_stall_cycles", stall_cycles, FWD ? 1 : 2);

      // 3: three r5 writers in flight; fourth waits for a retire
      do_reset();
      for (int i = 0; i < 3; i++) begin idle(); dec(1, 5, 0, 0); cycle(); end
      idle(); dec(1, 5, 0, 0); cycle();
      idle(); dec(1, 5, 0, 0); wb(5); cycle();
      idle(); dec(1, 5, 0, 0); cycle();
      idle(); cycle();
      check("t3_stall_cycles", stall_cycles, 0);

      // 4: redirect while decode has a hazard
      do_reset();
      idle(); dec(1, 3, 0, 0); cycle();
      idle(); dec(1, 9, 1, 3); redirect = 1; redirect_pc = 16'h0040; cycle();
      check("t4_in_flush", dbg_state, 1);
      idle(); dec(1, 9, 1, 3); cycle();
      check("t4_back_to_run", dbg_state, 0);
      idle(); dec(0, 0, 1, 9); cycle();
      check("t4_stall_cycles", stall_cycles, 0);
      check("t4_pc_target_held", pc_target, 16'h0040);

      // 5: r7 issue and r7 retire in the same cycle with one in flight
      do_reset();
      idle(); dec(1, 7, 0, 0); cycle();
      idle(); dec(1, 7, 0, 0); wb(7); cycle();
      idle(); dec(0, 0, 1, 7); cycle();
      check("t5_r7_still_pending", stall_cycles, 1);
      idle(); wb(7); cycle();

      // 6: underflow on r2 is sticky until reset
      do_reset();
      idle(); wb(2); cycle();
      check("t6_err_set", sb_err, 1);
      for (int i = 0; i < 3; i++) begin idle(); dec(1, 4, 0, 0); cycle(); end
      check("t6_err_sticky", sb_err, 1);
      do_reset();
      idle(); cycle();
      check("t6_err_cleared", sb_err, 0);

      // redirect during FLUSH is ignored and flagged
      do_reset();
      idle(); redirect = 1; redirect_pc = 16'h1234; cycle();
      idle(); redirect = 1; redirect_pc = 16'h5678; cycle();
      idle(); cycle();
      check("flush_redirect_err", sb_err, 1);
      check("flush_redirect_target", pc_target, 16'h1234);

      // randomized traffic with occasional reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rand_inputs(1'b1);
         n_rst = ($urandom_range(0, 199) != 0);
         cycle();
         n_rst = 1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Control-side counterpart to the i2d/d2a/a2w pipeline registers. Those registers only carry state forward; this block decides when they hold, bubble or flush, and when fetch stalls or redirects.
- Tracks in-flight register writes from decode issue to writeback retire with a per-register pending-count scoreboard.
- Sequences branch redirects through a small flush state machine.

Parameters:
NUM_REGS, 16, architectural registers tracked
REG_AW, 4, register address width (log2 NUM_REGS)
PC_W, 16, PC width; matches `PC_SIZE
CNT_W, 2, per-register pending counter width (max 3 in flight)

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
d_valid  in  1  decode-stage instruction valid
d_src0_en, d_src1_en  in  1 each  source operand used
d_src0, d_src1  in  REG_AW each  source register addresses
d_dst_en  in  1  instruction writes a register
d_dst  in  REG_AW  destination register
w_valid  in  1  writeback-stage instruction valid
w_en  in  1  writeback writes register file
w_addr  in  REG_AW  writeback destination
redirect  in  1  ALU-stage taken branch
redirect_pc  in  PC_W  branch target
fetch_stall  out  1  hold fetch PC
i2d_hold  out  1  i2d register keeps contents
d2a_bubble  out  1  d2a loads valid=0
i2d_flush, d2a_flush  out  1 each  clear stage valid
pc_load  out  1  fetch loads pc_target
pc_target  out  PC_W  redirect target
issue  out  1  decode instruction advances this cycle
stall_cycles  out  16  saturating count of raw-hazard stall cycles
sb_err  out  1  sticky scoreboard underflow

Behaviour:
- Reset: all counters 0, state RUN. All outputs 0, including pc_target, stall_cycles and sb_err.
- Hazard (combinational):
  - raw = d_valid & ((d_src0_en & cnt[d_src0]!=0) | (d_src1_en & cnt[d_src1]!=0)).
  - ovf = d_valid & d_dst_en & cnt[d_dst]==3.
  - hold = raw | ovf.
- State RUN, no redirect:
  - issue = d_valid & ~hold.
  - On hold: fetch_stall = i2d_hold = d2a_bubble = 1, same cycle. stall_cycles increments on raw only, saturating at 0xFFFF.
- Redirect in RUN:
  - Same cycle: i2d_flush = d2a_flush = pc_load = 1, pc_target = redirect_pc, issue = 0. Redirect overrides hold; fetch_stall = 0.
  - Next state FLUSH.
- FLUSH (one cycle):
  - i2d_flush = 1; issue = 0; d2a_bubble = 1.
  - Squashes the wrong-path instruction fetched during the redirect cycle.
  - Next state RUN. A redirect asserted in FLUSH is illegal; it is ignored and sets sb_err.
- Scoreboard update, every cycle:
  - cnt[d_dst] += issue & d_dst_en.
  - cnt[w_addr] -= w_valid & w_en.
  - Same register incremented and decremented in one cycle: net unchanged.
  - Decrement at 0: count stays 0 and sb_err sets. sb_err is cleared only by reset.
- Latency: a hazard stalls in the same cycle. A consumer of a producer's register issues the cycle after that producer's writeback (without the optional feature below).
- Reset mid-operation: counters, state and sb_err clear on the next edge regardless of inputs; flush and redirect are dropped.

Optional Feature:
HAZARD_FWD_EN: compiled in, a source whose pending count is exactly 1 and whose register equals w_addr while w_valid & w_en is treated as ready, so the consumer issues in the same cycle as the writeback (the datapath bypasses the write data). Compiled out, such a source stalls, and the consumer issues one cycle later.

Test Plan:
1. Reset with all inputs toggling -> after release, all outputs 0, all counters 0, issue follows d_valid.
2. Issue r3 write, then decode r3 source; writeback r3 two cycles later -> stall 2 cycles, stall_cycles=2, issue the cycle after writeback (same cycle with HAZARD_FWD_EN, stall_cycles=1).
3. Three back-to-back issues writing r5, fourth writer of r5 -> fourth held (ovf) until one r5 writeback, stall_cycles unchanged.
4. redirect=1 with redirect_pc=0x0040 while decode holds a hazard -> pc_load=1, pc_target=0x0040, both flushes asserted, issue=0, then one FLUSH cycle, then RUN; counter for the squashed dst unchanged.
5. Issue r7 write and r7 writeback in the same cycle with cnt[r7]=1 -> cnt[r7] stays 1.
6. Writeback to r2 with cnt[r2]=0 -> sb_err=1, stays 1 until n_rst=0.
